// File: rtl/launch_pkg.sv
// Shared types and default widths for the launch sequencer and its DM write-port mux.
package launch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CPU  = 1'b1
  } owner_t;

  localparam int DM_AW_DEF    = 8;
  localparam int DW_DEF       = 8;
  localparam int CNT_W_DEF    = 16;
  localparam int WD_LIMIT_DEF = 4096;

endpackage

// File: rtl/dm_port_mux.sv
// Combinational 2:1 select of the data-memory write port between host and CPU.
module dm_port_mux
  import launch_pkg::*;
#(
  parameter int AW = DM_AW_DEF,
  parameter int DW = DW_DEF
) (
  input  owner_t          owner,
  input  logic            host_wr_en,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_data,
  input  logic            cpu_wr_en,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_data,
  output logic            dm_wr_en,
  output logic [AW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_data
);

  // The non-owner's strobe never reaches DM, which is how stray writes get dropped.
  always_comb begin
    dm_wr_en = host_wr_en;
    dm_addr  = host_addr;
    dm_data  = host_data;
    if (owner == OWN_CPU) begin
      dm_wr_en = cpu_wr_en;
      dm_addr  = cpu_addr;
      dm_data  = cpu_data;
    end
  end

endmodule

// File: rtl/launch_ctrl.sv
// Run sequencer: host Start/Ack handshake -> CPU PC park/run control, halt detect, DM port ownership.
// Optional run watchdog enabled by defining LAUNCH_WATCHDOG_EN.
module launch_ctrl
  import launch_pkg::*;
#(
  parameter int DM_AW    = DM_AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int WD_LIMIT = WD_LIMIT_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  output logic              Ack,
  input  logic              HostWrEn,
  input  logic [DM_AW-1:0]  HostAddr,
  input  logic [DW-1:0]     HostData,
  output logic              HostBusy,
  input  logic              CpuHalt,
  input  logic              CpuMemWrEn,
  input  logic [DM_AW-1:0]  CpuMemAddr,
  input  logic [DW-1:0]     CpuMemData,
  output logic              DmWrEn,
  output logic [DM_AW-1:0]  DmAddr,
  output logic [DW-1:0]     DmData,
  output logic              PcReset,
  output logic              CpuRun,
  output logic [CNT_W-1:0]  CycleCount,
  output logic              Timeout
);

`ifdef LAUNCH_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WD_LIMIT - 1);

  state_t           state, state_nxt;
  owner_t           owner;
  logic [CNT_W-1:0] cycle_count;
  logic             wd_hit;

  // Start outranks both halt and watchdog so an abort always restarts cleanly.
  assign wd_hit = WD_EN && (state == RUN) && !Start && !CpuHalt && (cycle_count == WD_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      cycle_count <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == LOAD)
        cycle_count <= '0;
      else if (state == RUN && cycle_count != '1)
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (Start) state_nxt = LOAD;
      LOAD: if (!Start) state_nxt = RUN;
      RUN: begin
        if (Start)                 state_nxt = LOAD;
        else if (CpuHalt || wd_hit) state_nxt = DONE;
      end
      DONE: if (Start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PcReset  = 1'b1;
    CpuRun   = 1'b0;
    Ack      = 1'b0;
    HostBusy = 1'b0;
    owner    = OWN_HOST;
    unique case (state)
      RUN: begin
        PcReset  = 1'b0;
        CpuRun   = 1'b1;
        HostBusy = 1'b1;
        owner    = OWN_CPU;
      end
      DONE: begin
        PcReset = 1'b0;
        Ack     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef LAUNCH_WATCHDOG_EN
  // Sticky until the next LOAD so the host can read why the run ended.
  always_ff @(posedge Clk) begin
    if (Reset)                   Timeout <= 1'b0;
    else if (state_nxt == LOAD)  Timeout <= 1'b0;
    else if (wd_hit)             Timeout <= 1'b1;
  end
`else
  assign Timeout = 1'b0;
`endif

  assign CycleCount = cycle_count;

  dm_port_mux #(.AW(DM_AW), .DW(DW)) u_dm_mux (
    .owner      (owner),
    .host_wr_en (HostWrEn),
    .host_addr  (HostAddr),
    .host_data  (HostData),
    .cpu_wr_en  (CpuMemWrEn),
    .cpu_addr   (CpuMemAddr),
    .cpu_data   (CpuMemData),
    .dm_wr_en   (DmWrEn),
    .dm_addr    (DmAddr),
    .dm_data    (DmData)
  );

endmodule

// File: tb/tb_launch_ctrl.sv
// Scoreboard bench for launch_ctrl: DM writes and Ack rises are checked against a queue of expectations.
module tb_launch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, Start, Ack;
  logic        HostWrEn, HostBusy, CpuHalt, CpuMemWrEn;
  logic [7:0]  HostAddr, HostData, CpuMemAddr, CpuMemData;
  logic        DmWrEn;
  logic [7:0]  DmAddr, DmData;
  logic        PcReset, CpuRun, Timeout;
  logic [15:0] CycleCount;

  launch_ctrl #(.WD_LIMIT(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack),
    .HostWrEn(HostWrEn), .HostAddr(HostAddr), .HostData(HostData), .HostBusy(HostBusy),
    .CpuHalt(CpuHalt), .CpuMemWrEn(CpuMemWrEn), .CpuMemAddr(CpuMemAddr), .CpuMemData(CpuMemData),
    .DmWrEn(DmWrEn), .DmAddr(DmAddr), .DmData(DmData),
    .PcReset(PcReset), .CpuRun(CpuRun), .CycleCount(CycleCount), .Timeout(Timeout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_done;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [15:0] cnt;
    logic        to;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic       ack_prev = 1'b0;
  logic [7:0] dm [256];

  always @(posedge Clk) if (DmWrEn === 1'b1) dm[DmAddr] <= DmData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: output seen with empty scoreboard", name);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic exp_t mk_wr(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e = '{is_done: 1'b0, addr: a, data: d, cnt: 16'h0, to: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk_done(input logic [15:0] c, input logic t);
    exp_t e;
    e = '{is_done: 1'b1, addr: 8'h0, data: 8'h0, cnt: c, to: t};
    return e;
  endfunction

  // Monitor: pops an expectation for every DM write strobe and every Ack rise.
  always @(negedge Clk) begin
    exp_t e;
    if (DmWrEn === 1'b1) begin
      if (q.size() == 0) unexpected("dm_write");
      else begin
        e = q.pop_front();
        check("dm_kind", {31'd0, e.is_done}, 32'd0);
        check("dm_addr", {24'd0, DmAddr}, {24'd0, e.addr});
        check("dm_data", {24'd0, DmData}, {24'd0, e.data});
      end
    end
    if (Ack === 1'b1 && ack_prev !== 1'b1) begin
      if (q.size() == 0) unexpected("ack_rise");
      else begin
        e = q.pop_front();
        check("ack_kind",  {31'd0, e.is_done}, 32'd1);
        check("ack_count", {16'd0, CycleCount}, {16'd0, e.cnt});
        check("ack_timeout", {31'd0, Timeout}, {31'd0, e.to});
      end
    end
    ack_prev = Ack;
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; HostWrEn = 1'b0; HostAddr = '0; HostData = '0;
    CpuHalt = 1'b0; CpuMemWrEn = 1'b0; CpuMemAddr = '0; CpuMemData = '0;

    // 1: reset state
    step(2);
    Reset = 1'b0;
    check("rst_ack", {31'd0, Ack}, 32'd0);
    check("rst_pcreset", {31'd0, PcReset}, 32'd1);
    check("rst_cpurun", {31'd0, CpuRun}, 32'd0);
    check("rst_count", {16'd0, CycleCount}, 32'd0);
    check("rst_busy", {31'd0, HostBusy}, 32'd0);

    // 2: host preload in LOAD, then launch
    Start = 1'b1;
    step(1);
    q.push_back(mk_wr(8'd0, 8'd1));
    HostWrEn = 1'b1; HostAddr = 8'd0; HostData = 8'd1;
    step(1);
    q.push_back(mk_wr(8'd1, 8'd17));
    HostAddr = 8'd1; HostData = 8'd17;
    step(1);
    HostWrEn = 1'b0;
    check("load_cpurun", {31'd0, CpuRun}, 32'd0);
    check("load_pcreset", {31'd0, PcReset}, 32'd1);
    Start = 1'b0;
    step(1);
    check("run_cpurun", {31'd0, CpuRun}, 32'd1);
    check("run_pcreset", {31'd0, PcReset}, 32'd0);
    check("run_busy", {31'd0, HostBusy}, 32'd1);
    check("dm0", {24'd0, dm[0]}, 32'd1);
    check("dm1", {24'd0, dm[1]}, 32'd17);

    // 4: host write in RUN dropped, CPU write passes (RUN cycle 1)
    q.push_back(mk_wr(8'd9, 8'h2A));
    HostWrEn = 1'b1; HostAddr = 8'd5; HostData = 8'h55;
    CpuMemWrEn = 1'b1; CpuMemAddr = 8'd9; CpuMemData = 8'h2A;
    step(1);
    HostWrEn = 1'b0; CpuMemWrEn = 1'b0;
    check("dm9", {24'd0, dm[9]}, 32'h2A);

    // 3: halt during RUN cycle 37
    step(35);
    CpuHalt = 1'b1;
    q.push_back(mk_done(16'd37, 1'b0));
    step(1);
    CpuHalt = 1'b0;
    check("done_ack", {31'd0, Ack}, 32'd1);
    check("done_cpurun", {31'd0, CpuRun}, 32'd0);
    check("done_count", {16'd0, CycleCount}, 32'd37);
    check("done_timeout", {31'd0, Timeout}, 32'd0);
    check("done_busy", {31'd0, HostBusy}, 32'd0);
    step(3);
    check("done_ack_hold", {31'd0, Ack}, 32'd1);
    check("done_count_hold", {16'd0, CycleCount}, 32'd37);

    // 5a: reset mid-RUN
    Start = 1'b1;
    step(1);
    check("reload_count", {16'd0, CycleCount}, 32'd0);
    check("reload_ack", {31'd0, Ack}, 32'd0);
    Start = 1'b0;
    step(5);
    check("run4_count", {16'd0, CycleCount}, 32'd4);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    check("midrst_ack", {31'd0, Ack}, 32'd0);
    check("midrst_count", {16'd0, CycleCount}, 32'd0);
    check("midrst_pcreset", {31'd0, PcReset}, 32'd1);
    check("midrst_cpurun", {31'd0, CpuRun}, 32'd0);

    // 5b: Start and CpuHalt together in RUN -> LOAD
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    step(3);
    Start = 1'b1; CpuHalt = 1'b1;
    step(1);
    CpuHalt = 1'b0;
    check("abort_pcreset", {31'd0, PcReset}, 32'd1);
    check("abort_ack", {31'd0, Ack}, 32'd0);
    check("abort_count", {16'd0, CycleCount}, 32'd0);

    // CPU write strobe outside RUN must not reach DM
    CpuMemWrEn = 1'b1; CpuMemAddr = 8'd3; CpuMemData = 8'h77;
    #2;
    check("load_cpu_wr_ignored", {31'd0, DmWrEn}, 32'd0);
    step(1);
    CpuMemWrEn = 1'b0;

    // 6: watchdog
    Start = 1'b0;
`ifdef LAUNCH_WATCHDOG_EN
    q.push_back(mk_done(16'd16, 1'b1));
    step(1);
    step(16);
    check("wd_ack", {31'd0, Ack}, 32'd1);
    check("wd_timeout", {31'd0, Timeout}, 32'd1);
    check("wd_count", {16'd0, CycleCount}, 32'd16);
    Start = 1'b1;
    step(1);
    check("wd_timeout_clr", {31'd0, Timeout}, 32'd0);
    Start = 1'b0;
    step(1);
`else
    step(1);
    step(20);
    check("nowd_ack", {31'd0, Ack}, 32'd0);
    check("nowd_cpurun", {31'd0, CpuRun}, 32'd1);
    check("nowd_timeout", {31'd0, Timeout}, 32'd0);
    check("nowd_count", {16'd0, CycleCount}, 32'd20);
    CpuHalt = 1'b1;
    q.push_back(mk_done(16'd21, 1'b0));
    step(1);
    CpuHalt = 1'b0;
    check("nowd_ack_end", {31'd0, Ack}, 32'd1);
`endif

    step(2);
    check("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
